// File: rtl/cpu_pkg.sv
// Shared pipeline constants and register-index / data-word types.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// In-flight destination tracker: one busy bit per nonzero register, cleared by
// writeback, set on issue, with lookups that already honour a same-cycle writeback.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbEn,
  input  reg_idx_t              wbAddr,
  input  logic                  setEn,
  input  reg_idx_t              setIdx,
  input  reg_idx_t              lookA,
  input  reg_idx_t              lookB,
  input  reg_idx_t              lookD,
  output logic                  busyA,
  output logic                  busyB,
  output logic                  busyD,
  output logic [NUM_REGS-1:1]   busyVec,
  output logic                  sbErr
);

  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:0] busyFull;
  logic [NUM_REGS-1:1] busyNext;
  logic                wbLive;

  // Bit 0 is a constant zero so register 0 never reads busy.
  assign busyFull = {busy, 1'b0};
  assign wbLive   = wbEn && (wbAddr != '0);

  assign busyA = busyFull[lookA] && !(wbLive && wbAddr == lookA);
  assign busyB = busyFull[lookB] && !(wbLive && wbAddr == lookB);
  assign busyD = busyFull[lookD] && !(wbLive && wbAddr == lookD);

  always_comb begin
    busyNext = busy;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (wbLive && wbAddr == reg_idx_t'(i))
        busyNext[i] = 1'b0;
      if (setEn && setIdx == reg_idx_t'(i))
        busyNext[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      sbErr <= 1'b0;
    end else begin
      busy <= busyNext;
      if (wbLive && !busyFull[wbAddr])
        sbErr <= 1'b1;
    end
  end

  assign busyVec = busy;

endmodule

// File: rtl/operand_fetch_unit.sv
// Decode-side operand fetch: register-file read, writeback bypass, hazard stall
// against the scoreboard, and a registered handoff to execute.
module operand_fetch_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_src_a,
  input  logic [ADDR_W-1:0]    in_src_b,
  input  logic [ADDR_W-1:0]    in_dst,
  input  logic                 in_dst_en,
  output logic [ADDR_W-1:0]    rf_addr_a,
  output logic [ADDR_W-1:0]    rf_addr_b,
  input  logic [DATA_W-1:0]    rf_val_a,
  input  logic [DATA_W-1:0]    rf_val_b,
  input  logic                 wb_en,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]    wb_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_val_a,
  output logic [DATA_W-1:0]    out_val_b,
  output logic [ADDR_W-1:0]    out_dst,
  output logic                 out_dst_en,
  output logic [2**ADDR_W-1:1] busy_vec,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 sb_err
);

  logic              wbHitA, wbHitB;
  logic [DATA_W-1:0] opA, opB;
  logic              rawA, rawB, busyD, waw, hazard, accept;

  assign rf_addr_a = in_src_a;
  assign rf_addr_b = in_src_b;

  assign wbHitA = wb_en && (wb_addr == in_src_a) && (in_src_a != '0);
  assign wbHitB = wb_en && (wb_addr == in_src_b) && (in_src_b != '0);

  always_comb begin
    opA = rf_val_a;
    opB = rf_val_b;
    if (in_src_a == '0) opA = '0;
    else if (wbHitA)    opA = wb_val;
    if (in_src_b == '0) opB = '0;
    else if (wbHitB)    opB = wb_val;
  end

  reg_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .wbEn    (wb_en),
    .wbAddr  (wb_addr),
    .setEn   (accept && in_dst_en),
    .setIdx  (in_dst),
    .lookA   (in_src_a),
    .lookB   (in_src_b),
    .lookD   (in_dst),
    .busyA   (rawA),
    .busyB   (rawB),
    .busyD   (busyD),
    .busyVec (busy_vec),
    .sbErr   (sb_err)
  );

  assign waw      = in_dst_en && busyD;
  assign hazard   = rawA || rawB || waw;
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_val_a  <= '0;
      out_val_b  <= '0;
      out_dst    <= '0;
      out_dst_en <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_val_a  <= opA;
      out_val_b  <= opB;
      out_dst    <= in_dst;
      out_dst_en <= in_dst_en;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (in_valid && hazard && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule
